// File: rtl/d_reg_pipe_pkg.sv
// d_reg_pipe_pkg
//   Helpers shared by the pipeline blocks. No typedefs are needed here.
//   The occupancy counter width function lives here so other pipeline
//   blocks size their counters the same way.
package d_reg_pipe_pkg;

  // Bits needed to count 0..depth inclusive.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/d_reg_pipe_if.sv
// d_reg_pipe_if
//   Valid/ready handshake bundle for both ends of an elastic pipeline.
//   Signals:
//     in_data/in_valid   upstream word and its valid
//     in_ready           pipeline accepts the upstream word this cycle
//     out_data/out_valid last-stage word and its valid
//     out_ready          downstream accepts the output word this cycle
//   Modports:
//     slave  - the pipeline itself
//     master - whoever drives the upstream side and consumes the output
interface d_reg_pipe_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );
endinterface

// File: rtl/d_reg_stage.sv
// d_reg_stage
//   One pipeline stage: a valid bit plus a WIDTH-bit data register.
//   Ports:
//     clk, rst     clock, synchronous active-high reset
//     flush        synchronous clear of the valid bit (data kept)
//     up_valid     valid of the upstream stage / input
//     up_data      data of the upstream stage / input
//     down_ready   ready of the downstream stage / output
//     valid, data  registered stage contents
//     ready        this stage can take a word this cycle (combinational)
module d_reg_stage #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             down_ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             ready
);

  // An empty stage always accepts, which lets bubbles collapse under stall.
  assign ready = !valid || down_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= RST_VAL;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (ready) begin
      valid <= up_valid;
      // A bubble moving in must not overwrite the held data.
      if (up_valid) begin
        data <= up_data;
      end
    end
  end

endmodule

// File: rtl/d_reg_pipe.sv
// d_reg_pipe
//   Elastic register pipeline of DEPTH stages, WIDTH bits each, with a
//   valid/ready handshake at both ends, flush and occupancy count.
//   Ports:
//     clk, rst   clock, synchronous active-high reset
//     flush      synchronous clear of all valid bits; blocks input
//     bus        d_reg_pipe_if slave (in_*/out_* handshake)
//     occupancy  number of valid stages (registered)
module d_reg_pipe
  import d_reg_pipe_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  d_reg_pipe_if.slave                  bus,
  output logic [occ_width(DEPTH)-1:0]  occupancy
);

  localparam int OCC_W = occ_width(DEPTH);

  logic [DEPTH:0]   rdy;
  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] up_vld;
  logic [DEPTH-1:0] nxt_vld;
  logic [WIDTH-1:0] dat    [DEPTH];
  logic [WIDTH-1:0] up_dat [DEPTH];
  logic [OCC_W-1:0] occ_nxt;

  // Ready propagates combinationally from the output back to the input.
  assign rdy[DEPTH] = bus.out_ready;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_first
      assign up_vld[i] = bus.in_valid;
      assign up_dat[i] = bus.in_data;
    end else begin : g_rest
      assign up_vld[i] = vld[i-1];
      assign up_dat[i] = dat[i-1];
    end

    d_reg_stage #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
    ) u_stage (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .up_valid   (up_vld[i]),
      .up_data    (up_dat[i]),
      .down_ready (rdy[i+1]),
      .valid      (vld[i]),
      .data       (dat[i]),
      .ready      (rdy[i])
    );
  end

  assign bus.in_ready  = rdy[0] && !flush;
  assign bus.out_valid = vld[DEPTH-1];
  assign bus.out_data  = dat[DEPTH-1];

  // Mirror of the stage valid update so occupancy can be registered
  // alongside the valid bits; rst/flush are applied at the register.
  always_comb begin
    nxt_vld = '0;
    occ_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      nxt_vld[i] = rdy[i] ? up_vld[i] : vld[i];
      occ_nxt    = occ_nxt + OCC_W'(nxt_vld[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      occupancy <= '0;
    end else begin
      occupancy <= occ_nxt;
    end
  end

endmodule

// File: tb/tb_d_reg_pipe.sv
// tb_d_reg_pipe
//   Directed bench for d_reg_pipe with DEPTH=3, WIDTH=8, RST_VAL=8'hA5.
module tb_d_reg_pipe;
  localparam int         WIDTH = 8;
  localparam int         DEPTH = 3;
  localparam logic [7:0] RSTV  = 8'hA5;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [1:0] occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  d_reg_pipe_if #(.WIDTH(WIDTH)) bus ();

  d_reg_pipe #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .RST_VAL (RSTV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .bus       (bus),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst          = 1'b1;
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.out_ready = 1'b0;

    // reset
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data",  32'(bus.out_data),  32'hA5);
    chk("rst_occ",       32'(occupancy),     32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);

    // streaming 01..0A, word k accepted at edge k appears after edge k+2
    bus.out_ready = 1'b1;
    for (int c = 0; c < 14; c++) begin
      bus.in_valid = (c < 10);
      bus.in_data  = 8'(c + 1);
      #1;
      chk("stream_in_ready", 32'(bus.in_ready), 32'd1);
      tick();
      chk("stream_out_valid", 32'(bus.out_valid), 32'((c >= 2) && (c <= 11)));
      if ((c >= 2) && (c <= 11)) begin
        chk("stream_out_data", 32'(bus.out_data), 32'(c - 1));
      end
    end
    chk("stream_hold_data", 32'(bus.out_data), 32'h0A);
    chk("stream_occ_empty", 32'(occupancy), 32'd0);

    // back-pressure
    bus.out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(8'h21 + c);
      #1;
      chk("bp_in_ready", 32'(bus.in_ready), 32'd1);
      tick();
    end
    chk("bp_occ_full", 32'(occupancy), 32'd3);
    chk("bp_out_data", 32'(bus.out_data), 32'h21);
    bus.in_data = 8'h24;
    #1;
    chk("bp_full_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    chk("bp_hold_occ",  32'(occupancy), 32'd3);
    chk("bp_hold_data", 32'(bus.out_data), 32'h21);
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("bp_swap_occ",  32'(occupancy), 32'd3);
    chk("bp_drain_22",  32'(bus.out_data), 32'h22);
    tick();
    chk("bp_drain_23",  32'(bus.out_data), 32'h23);
    chk("bp_occ2",      32'(occupancy), 32'd2);
    tick();
    chk("bp_drain_24",  32'(bus.out_data), 32'h24);
    chk("bp_occ1",      32'(occupancy), 32'd1);
    tick();
    chk("bp_empty_valid", 32'(bus.out_valid), 32'd0);
    chk("bp_empty_occ",   32'(occupancy), 32'd0);

    // bubble collapse under stall
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h11;
    #1;
    chk("bub_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("bub_occ", 32'(occupancy), 32'd1);
    chk("bub_out_valid0", 32'(bus.out_valid), 32'd0);
    tick();
    chk("bub_out_valid1", 32'(bus.out_valid), 32'd0);
    tick();
    chk("bub_out_valid2", 32'(bus.out_valid), 32'd1);
    chk("bub_out_data",   32'(bus.out_data), 32'h11);
    chk("bub_occ_end",    32'(occupancy), 32'd1);
    chk("bub_in_ready2",  32'(bus.in_ready), 32'd1);

    // flush with input presented
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h31;
    tick();
    bus.in_data  = 8'h32;
    tick();
    chk("fl_pre_occ", 32'(occupancy), 32'd3);
    bus.in_data = 8'h77;
    flush       = 1'b1;
    #1;
    chk("fl_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    chk("fl_occ",       32'(occupancy), 32'd0);
    chk("fl_out_valid", 32'(bus.out_valid), 32'd0);
    chk("fl_out_data",  32'(bus.out_data), 32'h11);
    bus.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("fl_no_77", 32'(bus.out_valid), 32'd0);
    end

    // rst and flush together
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h41;
    tick();
    bus.in_data   = 8'h42;
    tick();
    bus.in_valid  = 1'b0;
    chk("rf_pre_occ", 32'(occupancy), 32'd2);
    rst   = 1'b1;
    flush = 1'b1;
    tick();
    rst   = 1'b0;
    flush = 1'b0;
    #1;
    chk("rf_out_data",  32'(bus.out_data), 32'hA5);
    chk("rf_occ",       32'(occupancy), 32'd0);
    chk("rf_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rf_in_ready",  32'(bus.in_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
